// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control path: instruction types, default
// multi-cycle function codes and the sequencer state type.
package alu_pkg;

    localparam logic [1:0] OP_TYPE_A = 2'b00;
    localparam logic [1:0] OP_TYPE_B = 2'b01;
    localparam logic [1:0] OP_TYPE_C = 2'b10;
    localparam logic [1:0] OP_TYPE_D = 2'b11;

    localparam logic [3:0] MUL_CODE_DEF = 4'b1100;
    localparam logic [3:0] DIV_CODE_DEF = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_cnt_decode.sv
// Combinational map from instruction type and function code to the ALU
// control word, plus a flag marking type-A codes that run on the iterative path.
module alu_cnt_decode
    import alu_pkg::*;
#(
    parameter int                 FUNCT_W  = 4,
    parameter int                 CNT_W    = 4,
    parameter logic [FUNCT_W-1:0] MUL_CODE = MUL_CODE_DEF,
    parameter logic [FUNCT_W-1:0] DIV_CODE = DIV_CODE_DEF
) (
    input  logic [1:0]         alu_op,
    input  logic [FUNCT_W-1:0] funct_code,
    output logic [CNT_W-1:0]   cnt_word,
    output logic               is_mc
);

    // Control word and multi-cycle classification
    always_comb begin
        cnt_word = {CNT_W{1'b0}};
        is_mc    = 1'b0;
        case (alu_op)
            OP_TYPE_A: begin
                cnt_word = CNT_W'(funct_code);
                if ((funct_code == MUL_CODE) || (funct_code == DIV_CODE)) begin
                    is_mc = 1'b1;
                end else begin
                    is_mc = 1'b0;
                end
            end
            OP_TYPE_B: cnt_word = {CNT_W{1'b1}};
            OP_TYPE_C: cnt_word = {CNT_W{1'b0}};
            OP_TYPE_D: cnt_word = {CNT_W{1'b0}};
            default:   cnt_word = {CNT_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control unit: decodes issued instructions into a control word
// and sequences multi-cycle multiply/divide iterations, stalling issue meanwhile.
module alu_ctrl_seq
    import alu_pkg::*;
#(
    parameter int                 FUNCT_W   = 4,
    parameter int                 CNT_W     = 4,
    parameter int                 MC_CYCLES = 8,
    parameter logic [FUNCT_W-1:0] MUL_CODE  = MUL_CODE_DEF,
    parameter logic [FUNCT_W-1:0] DIV_CODE  = DIV_CODE_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    output logic                         issue_ready,
    input  logic [1:0]                   alu_op,
    input  logic [FUNCT_W-1:0]           funct_code,
    input  logic                         flush,
    output logic [CNT_W-1:0]             alu_cnt,
    output logic                         alu_valid,
    output logic                         mc_step,
    output logic [$clog2(MC_CYCLES)-1:0] mc_iter,
    output logic                         mc_busy
);

    localparam int                ITER_W    = $clog2(MC_CYCLES);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MC_CYCLES - 1);

    state_t              state_r;
    state_t              next_state_s;
    logic [CNT_W-1:0]    dec_cnt_s;
    logic                dec_is_mc_s;
    logic [CNT_W-1:0]    alu_cnt_r;
    logic                alu_valid_r;
    logic                next_valid_s;
    logic [ITER_W-1:0]   mc_iter_r;
    logic [ITER_W-1:0]   next_iter_s;
    logic                issue_ready_s;
    logic                accept_s;

    alu_cnt_decode #(
        .FUNCT_W  (FUNCT_W),
        .CNT_W    (CNT_W),
        .MUL_CODE (MUL_CODE),
        .DIV_CODE (DIV_CODE)
    ) u_decode (
        .alu_op     (alu_op),
        .funct_code (funct_code),
        .cnt_word   (dec_cnt_s),
        .is_mc      (dec_is_mc_s)
    );

    // Ready depends only on state and flush so the issue handshake has no loop
    always_comb begin
        issue_ready_s = 1'b0;
        case (state_r)
            IDLE:    issue_ready_s = ~flush;
            DONE:    issue_ready_s = ~flush;
            RUN:     issue_ready_s = 1'b0;
            default: issue_ready_s = 1'b0;
        endcase
    end

    assign accept_s = issue_valid & issue_ready_s;

    // Next state, next iteration index and next completion pulse
    always_comb begin
        next_state_s = state_r;
        next_iter_s  = mc_iter_r;
        next_valid_s = 1'b0;
        if (flush) begin
            next_state_s = IDLE;
            next_iter_s  = {ITER_W{1'b0}};
            next_valid_s = 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s && dec_is_mc_s) begin
                        next_state_s = RUN;
                        next_iter_s  = {ITER_W{1'b0}};
                    end else if (accept_s) begin
                        next_state_s = IDLE;
                        next_valid_s = 1'b1;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                RUN: begin
                    if (mc_iter_r == LAST_ITER) begin
                        next_state_s = DONE;
                        next_iter_s  = {ITER_W{1'b0}};
                        next_valid_s = 1'b1;
                    end else begin
                        next_state_s = RUN;
                        next_iter_s  = mc_iter_r + ITER_W'(1);
                    end
                end
                default: begin
                    next_state_s = IDLE;
                    next_iter_s  = {ITER_W{1'b0}};
                end
            endcase
        end
    end

    // Sequencer state, iteration counter and completion pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            mc_iter_r   <= {ITER_W{1'b0}};
            alu_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            mc_iter_r   <= next_iter_s;
            alu_valid_r <= next_valid_s;
        end
    end

    // Control word is captured on accept and otherwise held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            alu_cnt_r <= dec_cnt_s;
        end else begin
            alu_cnt_r <= alu_cnt_r;
        end
    end

    assign issue_ready = issue_ready_s;
    assign alu_cnt     = alu_cnt_r;
    assign alu_valid   = alu_valid_r;
    assign mc_iter     = mc_iter_r;
    assign mc_busy     = (state_r == RUN);
    assign mc_step     = (state_r == RUN);

endmodule
